// File: rtl/events_apb_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : events_apb_pkg
//  Brief   : Shared address map, FSM state type and status bit indices for
//            the APB event-count completer.
//  Rev     : 1.0  initial release
// ============================================================================
package events_apb_pkg;

    localparam logic [31:0] ADDR_A_DEF    = 32'hABBA0000;
    localparam logic [31:0] ADDR_B_DEF    = 32'hBAFF0000;
    localparam logic [31:0] ADDR_C_DEF    = 32'hCAFE0000;
    localparam logic [31:0] ADDR_STAT_DEF = 32'h57A70000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    localparam int STAT_GAP_A = 0;
    localparam int STAT_GAP_B = 1;
    localparam int STAT_GAP_C = 2;
    localparam int STAT_PERR  = 3;

endpackage
`default_nettype wire

// File: rtl/evt_cnt_reg.sv
`default_nettype none
// ============================================================================
//  Module  : evt_cnt_reg
//  Brief   : One event-count register with sequence-gap detection, sticky
//            write-1-to-clear gap flag and a one-cycle update pulse.
//  Rev     : 1.0  initial release
// ============================================================================
module evt_cnt_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_wr_en,
    input  logic [31:0] i_wdata,
    input  logic        i_clr,
    output logic [31:0] o_cnt,
    output logic        o_upd,
    output logic        o_gap
);

    logic [31:0] r_cnt;
    logic        r_upd;
    logic        r_gap;
    logic [31:0] w_expect;
    logic        w_is_gap;

    // Modulo-2^32 increment, so a wrap from all-ones to zero is in sequence.
    assign w_expect = r_cnt + 32'd1;
    assign w_is_gap = (i_wdata != w_expect);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            r_upd <= 1'b0;
            r_gap <= 1'b0;
        end else begin
            r_upd <= i_wr_en;
            if (i_wr_en) begin
                r_cnt <= i_wdata;
            end
            if (i_wr_en && w_is_gap) begin
                r_gap <= 1'b1;
            end else if (i_clr) begin
                r_gap <= 1'b0;
            end
        end
    end

    assign o_cnt = r_cnt;
    assign o_upd = r_upd;
    assign o_gap = r_gap;

endmodule
`default_nettype wire

// File: rtl/apb_event_cnt_slave.sv
`default_nettype none
// ============================================================================
//  Module  : apb_event_cnt_slave
//  Brief   : APB completer holding three event-count registers, sticky gap /
//            protocol-error status and programmable wait states.
//  Rev     : 1.0  initial release
// ============================================================================
module apb_event_cnt_slave
    import events_apb_pkg::*;
#(
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] ADDR_A      = ADDR_A_DEF,
    parameter logic [31:0] ADDR_B      = ADDR_B_DEF,
    parameter logic [31:0] ADDR_C      = ADDR_C_DEF,
    parameter logic [31:0] ADDR_STAT   = ADDR_STAT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        apb_psel_i,
    input  logic        apb_penable_i,
    input  logic [31:0] apb_paddr_i,
    input  logic        apb_pwrite_i,
    input  logic [31:0] apb_pwdata_i,
    output logic        apb_pready_o,
    output logic [31:0] apb_prdata_o,
    output logic        apb_pslverr_o,
    output logic [31:0] cnt_a_o,
    output logic [31:0] cnt_b_o,
    output logic [31:0] cnt_c_o,
    output logic [2:0]  upd_o,
    output logic [2:0]  gap_o
);

    localparam logic [3:0] c_WAIT_TGT = 4'(WAIT_STATES);

    apb_state_t  r_state;
    logic [3:0]  r_wait_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_write;
    logic        r_perr;

    logic        w_pready;
    logic [2:0]  w_hit;
    logic        w_hit_stat;
    logic        w_hit_any;
    logic [2:0]  w_wr_en;
    logic        w_stat_wr;
    logic [2:0]  w_clr;
    logic [31:0] w_cnt [3];
    logic [2:0]  w_upd;
    logic [2:0]  w_gap;
    logic [31:0] w_rdata;

    assign w_pready = (r_state == ACCESS) && apb_psel_i && apb_penable_i
                      && (r_wait_cnt == c_WAIT_TGT);

    assign w_hit[STAT_GAP_A] = (r_addr == ADDR_A);
    assign w_hit[STAT_GAP_B] = (r_addr == ADDR_B);
    assign w_hit[STAT_GAP_C] = (r_addr == ADDR_C);
    assign w_hit_stat        = (r_addr == ADDR_STAT);
    assign w_hit_any         = (|w_hit) || w_hit_stat;

    assign w_wr_en   = {3{w_pready && r_write}} & w_hit;
    assign w_stat_wr = w_pready && r_write && w_hit_stat;
    assign w_clr     = w_stat_wr ? r_wdata[2:0] : 3'b000;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_ch
            evt_cnt_reg u_cnt_reg (
                .clk     (clk),
                .reset   (reset),
                .i_wr_en (w_wr_en[gi]),
                .i_wdata (r_wdata),
                .i_clr   (w_clr[gi]),
                .o_cnt   (w_cnt[gi]),
                .o_upd   (w_upd[gi]),
                .o_gap   (w_gap[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_wait_cnt <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_write    <= 1'b0;
            r_perr     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (apb_psel_i && !apb_penable_i) begin
                        r_state    <= SETUP;
                        r_wait_cnt <= '0;
                        r_addr     <= apb_paddr_i;
                        r_wdata    <= apb_pwdata_i;
                        r_write    <= apb_pwrite_i;
                    end
                end
                SETUP: begin
                    if (!apb_psel_i) begin
                        r_state <= IDLE;
                    end else if (apb_penable_i) begin
                        r_state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!apb_psel_i) begin
                        r_state <= IDLE;
                    end else if (!apb_penable_i) begin
                        r_state    <= SETUP;
                        r_wait_cnt <= '0;
                        r_addr     <= apb_paddr_i;
                        r_wdata    <= apb_pwdata_i;
                        r_write    <= apb_pwrite_i;
                    end else if (w_pready) begin
                        r_state <= IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 4'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase

            // An access phase with no preceding setup is flagged and dropped.
            if ((r_state == IDLE) && apb_psel_i && apb_penable_i) begin
                r_perr <= 1'b1;
            end else if (w_stat_wr && r_wdata[STAT_PERR]) begin
                r_perr <= 1'b0;
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        if (w_pready && !r_write) begin
            if (w_hit[STAT_GAP_A]) begin
                w_rdata = w_cnt[0];
            end else if (w_hit[STAT_GAP_B]) begin
                w_rdata = w_cnt[1];
            end else if (w_hit[STAT_GAP_C]) begin
                w_rdata = w_cnt[2];
            end else if (w_hit_stat) begin
                w_rdata = {28'b0, r_perr, w_gap};
            end
        end
    end

    assign apb_pready_o  = w_pready;
    assign apb_prdata_o  = w_rdata;
    assign apb_pslverr_o = w_pready && !w_hit_any;
    assign cnt_a_o       = w_cnt[0];
    assign cnt_b_o       = w_cnt[1];
    assign cnt_c_o       = w_cnt[2];
    assign upd_o         = w_upd;
    assign gap_o         = w_gap;

endmodule
`default_nettype wire
